// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: folds PS/2 set-2 prefix bytes (E0/F0/E1) into single key events
// with modifier tracking and a one-deep valid/ready event register.
module ps2_kbd_decoder #(
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic [7:0] data,
    output logic       done,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [3:0] mods,
    output logic       err
);
    localparam int W = $clog2(PAUSE_SKIP + 1);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;
    state_t state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic emit, emit_ext, emit_brk, set_err, fresh, fake_shift;
    // {rgui, lgui, ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic [7:0] held, held_nx;
    assign done = rdy & (~evt_valid | evt_ready) & ~rst;
    assign mods = {held[7] | held[6], held[5] | held[4], held[3] | held[2], held[1] | held[0]};
    assign fresh = state == IDLE || (state == EXT && (data == 8'hE0 || data == 8'hE1));
    assign fake_shift = data == 8'h12 || data == 8'h59;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        emit = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        set_err = 1'b0;
        if (state == SKIP) begin
            cnt_nx = cnt - 1'b1;
            state_nx = cnt == W'(1) ? IDLE : SKIP;
        end else if (fresh) begin
            state_nx = IDLE;
            if (data == 8'hE0) state_nx = EXT;
            else if (data == 8'hF0) state_nx = BRK;
            else if (data == 8'hE1) begin
                state_nx = SKIP;
                cnt_nx = W'(PAUSE_SKIP);
            end else if (data == 8'h00 || data == 8'hFF) set_err = 1'b1;
            else if (!(data == 8'hAA || data == 8'hFA || data == 8'hFE || data == 8'hEE)) emit = 1'b1;
        end else if (state == EXT) begin
            state_nx = data == 8'hF0 ? EXTBRK : IDLE;
            emit = data != 8'hF0 && !fake_shift;
            emit_ext = 1'b1;
        end else begin
            state_nx = IDLE;
            emit = state == BRK || !fake_shift;
            emit_ext = state == EXTBRK;
            emit_brk = 1'b1;
        end
    end
    always_comb begin
        held_nx = held;
        if (emit) begin
            if (!emit_ext && data == 8'h12) held_nx[0] = ~emit_brk;
            if (!emit_ext && data == 8'h59) held_nx[1] = ~emit_brk;
            if (!emit_ext && data == 8'h14) held_nx[2] = ~emit_brk;
            if (emit_ext && data == 8'h14) held_nx[3] = ~emit_brk;
            if (!emit_ext && data == 8'h11) held_nx[4] = ~emit_brk;
            if (emit_ext && data == 8'h11) held_nx[5] = ~emit_brk;
            if (emit_ext && data == 8'h1F) held_nx[6] = ~emit_brk;
            if (emit_ext && data == 8'h27) held_nx[7] = ~emit_brk;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            held <= '0;
            err <= 1'b0;
            evt_valid <= 1'b0;
            evt_code <= '0;
            evt_ext <= 1'b0;
            evt_break <= 1'b0;
        end else begin
            if (done) begin
                state <= state_nx;
                cnt <= cnt_nx;
                held <= held_nx;
                err <= err | set_err;
                if (emit) begin
                    evt_code <= data;
                    evt_ext <= emit_ext;
                    evt_break <= emit_brk;
                end
            end
            evt_valid <= (done && emit) ? 1'b1 : evt_ready ? 1'b0 : evt_valid;
        end
    end
endmodule
